vreg_port_arbiter: RTL and testbench
====================================

# vreg_port_arbiter

Shares one vector-register-file access port among NUM_REQ requesters (lane read ports and write-buffer write ports of a single-threaded pipeline) using round-robin arbitration. Accepted requests go to the register file through a single output register. The block keeps an in-order tag FIFO of outstanding reads so that each read response returns to the requester that issued it. It sits between the execution/write-buffer request ports and one register-file bank.

## Interface
- NUM_REQ, 4, number of requesters
- DATA_W, VECTOR_REG_WIDTH, read/write data width
- REG_W, $clog2(NUM_OF_VECTOR_REG), register index width
- ADDR_W, ADDR_FIELD_WIDTH, element address width
- MAX_OUTSTANDING, 4, maximum in-flight reads (tag FIFO depth, power of 2)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_vld[NUM_REQ]  in  1 each  request valid; held until granted
- req_wr[NUM_REQ]  in  1 each  1 = write, 0 = read
- req_reg[NUM_REQ]  in  REG_W each  register index
- req_addr[NUM_REQ]  in  ADDR_W each  element address
- req_wdata[NUM_REQ]  in  DATA_W each  write data
- req_grant[NUM_REQ]  out  1 each  one-cycle accept pulse, combinational
- rsp_vld[NUM_REQ]  out  1 each  read data valid, registered
- rsp_data  out  DATA_W  read data, broadcast to all requesters
- rf_req_vld, rf_req_wr  out  1  register-file request
- rf_req_reg  out  REG_W  register-file request
- rf_req_addr  out  ADDR_W  register-file request
- rf_req_wdata  out  DATA_W  register-file request
- rf_busy  in  1  register file cannot accept this cycle
- rf_rsp_vld  in  1  read response valid; responses arrive in order
- rf_rsp_data  in  DATA_W  read response data
- err_unexpected_rsp  out  1  sticky; set by a response while no read is outstanding

## Operation
- Output register (OREG): holds at most one request. It is consumed in any cycle where rf_req_vld=1 and rf_busy=0.
- Grant enable: OREG is empty or is consumed this cycle.
- Eligibility of requester i: req_vld[i]=1, plus one of:
  - req_wr[i]=1 (writes are always eligible), or
  - outstanding < MAX_OUTSTANDING (reads).
- Arbitration: round-robin over eligible requesters. The search starts at rr_ptr and wraps modulo NUM_REQ. At most one grant per cycle.
- On grant to requester g:
  - OREG loads g's fields.
  - rr_ptr becomes (g+1) mod NUM_REQ.
  - If the request is a read, tag g is pushed into the tag FIFO and outstanding increments.
- rr_ptr does not change in a cycle with no grant.
- Read return: on rf_rsp_vld, the block pops the tag FIFO head h. Next cycle rsp_vld[h]=1 and rsp_data=rf_rsp_data. Outstanding decrements.
- Same-cycle read grant and response: outstanding is unchanged, and push and pop both occur.
- rf_rsp_vld with the FIFO empty: response dropped, err_unexpected_rsp set, no rsp_vld asserted.
- Writes produce no response.

## Timing
- Reset (asynchronous, reset=0):
  - rf_req_vld=0, rsp_vld all 0, err_unexpected_rsp=0.
  - rr_ptr=0, outstanding=0, tag FIFO empty.
  - rsp_data and rf_req_* data fields reset to 0.
- Reset mid-operation discards all in-flight tags. Responses arriving after reset release set err_unexpected_rsp.
- Grant latency: req_grant in the same cycle req_vld is seen (if eligible). rf_req_vld is asserted the next cycle.
- Back-to-back: with rf_busy=0, one grant per cycle and full throughput.
- rf_busy=1 with OREG full: no grants; OREG held stable. A grant in the cycle rf_busy drops refills OREG with no bubble.
- Response latency: rsp_vld exactly 1 cycle after rf_rsp_vld.
- Requester protocol: fields stay stable while req_vld=1 and no grant. Deassertion without a grant is allowed.

## Test plan
- Reset, then single read. req_vld[2]=1, read reg 5, addr 3 -> req_grant[2] in cycle 0. rf_req_vld=1 with reg=5, addr=3 in cycle 1. rf_rsp_vld with data 0xA5 in cycle 4 -> rsp_vld[2]=1, rsp_data=0xA5 in cycle 5.
- Round-robin fairness. All 4 requesters issue writes continuously with rf_busy=0 -> grant order 0,1,2,3,0,1… with one grant per cycle.
- Outstanding limit. 5 reads from requester 1 with no responses -> 4 grants, then none. The first rf_rsp_vld allows the 5th grant in that same cycle. Writes from requester 3 are still granted while the limit is reached.
- Backpressure. rf_busy=1 for 3 cycles with OREG full -> no grants, rf_req_* stable. rf_busy=0 -> OREG consumed and the next grant in the same cycle.
- Response routing. Reads granted to requesters 3, 0, 2 -> three in-order responses give rsp_vld[3], rsp_vld[0], rsp_vld[2] in that sequence.
- Errors and reset. rf_rsp_vld with no outstanding reads -> err_unexpected_rsp=1 and sticky. Asynchronous reset asserted mid-burst -> all outputs zero immediately.

Source files
------------

// File: rtl/vreg_port_arbiter.sv
// Round-robin arbiter sharing one vector-register-file port among NUM_REQ requesters.
// Accepted requests pass through a single output register; an in-order tag FIFO routes
// each read response back to the requester that issued the read.
module vreg_port_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned NUM_OF_VECTOR_REG = 32,
    parameter int unsigned VECTOR_REG_WIDTH  = 64,
    parameter int unsigned ADDR_FIELD_WIDTH  = 4,
    parameter int unsigned DATA_W            = VECTOR_REG_WIDTH,
    parameter int unsigned REG_W             = $clog2(NUM_OF_VECTOR_REG),
    parameter int unsigned ADDR_W            = ADDR_FIELD_WIDTH,
    parameter int unsigned MAX_OUTSTANDING   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_vld,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ-1:0][REG_W-1:0]  req_reg,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0]             rsp_vld,
    output logic [DATA_W-1:0]              rsp_data,
    output logic                           rf_req_vld,
    output logic                           rf_req_wr,
    output logic [REG_W-1:0]               rf_req_reg,
    output logic [ADDR_W-1:0]              rf_req_addr,
    output logic [DATA_W-1:0]              rf_req_wdata,
    input  logic                           rf_busy,
    input  logic                           rf_rsp_vld,
    input  logic [DATA_W-1:0]              rf_rsp_data,
    output logic                           err_unexpected_rsp
);

    localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                                   oreg_vld_q, oreg_vld_d;
    logic                                   oreg_wr_q, oreg_wr_d;
    logic [REG_W-1:0]                       oreg_reg_q, oreg_reg_d;
    logic [ADDR_W-1:0]                      oreg_addr_q, oreg_addr_d;
    logic [DATA_W-1:0]                      oreg_wdata_q, oreg_wdata_d;
    logic [TAG_W-1:0]                       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                       outstanding_q, outstanding_d;
    logic [MAX_OUTSTANDING-1:0][TAG_W-1:0]  tag_mem_q, tag_mem_d;
    logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
    logic [NUM_REQ-1:0]                     rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0]                      rsp_data_q, rsp_data_d;
    logic                                   err_q, err_d;

    logic                                   grant_en;
    logic                                   pop;
    logic                                   push;
    logic                                   rd_ok;
    logic [NUM_REQ-1:0]                     eligible;
    logic                                   grant_any;
    logic [TAG_W-1:0]                       grant_idx;
    logic [NUM_REQ-1:0]                     grant;

    // Round-robin search from rr_ptr over eligible requesters; one grant at most.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_en  = !oreg_vld_q || !rf_busy;
        pop       = rf_rsp_vld && (outstanding_q != '0);
        // A response popping this cycle frees a slot for a read granted in the same cycle.
        rd_ok     = (outstanding_q < CNT_W'(MAX_OUTSTANDING)) || pop;
        eligible  = req_vld & (req_wr | {NUM_REQ{rd_ok}});
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (grant_en && !grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = TAG_W'(idx);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
        // Held in reset the block presents no grants.
        req_grant = grant & {NUM_REQ{reset}};
        push      = grant_any && !req_wr[grant_idx];
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        oreg_vld_d   = oreg_vld_q;
        oreg_wr_d    = oreg_wr_q;
        oreg_reg_d   = oreg_reg_q;
        oreg_addr_d  = oreg_addr_q;
        oreg_wdata_d = oreg_wdata_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant_any) begin
            oreg_vld_d   = 1'b1;
            oreg_wr_d    = req_wr[grant_idx];
            oreg_reg_d   = req_reg[grant_idx];
            oreg_addr_d  = req_addr[grant_idx];
            oreg_wdata_d = req_wdata[grant_idx];
            rr_ptr_d     = TAG_W'((int'(grant_idx) + 1) % NUM_REQ);
        end else if (oreg_vld_q && !rf_busy) begin
            oreg_vld_d = 1'b0;
        end
    end

    // Tag FIFO, outstanding count and response routing.
    always_comb begin
        tag_mem_d     = tag_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        rsp_vld_d     = '0;
        rsp_data_d    = rsp_data_q;
        err_d         = err_q | (rf_rsp_vld && (outstanding_q == '0));
        if (push) begin
            tag_mem_d[wr_ptr_q] = grant_idx;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rsp_vld_d[tag_mem_q[rd_ptr_q]] = 1'b1;
            rsp_data_d                     = rf_rsp_data;
            rd_ptr_d                       = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oreg_vld_q    <= 1'b0;
            oreg_wr_q     <= 1'b0;
            oreg_reg_q    <= '0;
            oreg_addr_q   <= '0;
            oreg_wdata_q  <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            tag_mem_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rsp_vld_q     <= '0;
            rsp_data_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            oreg_vld_q    <= oreg_vld_d;
            oreg_wr_q     <= oreg_wr_d;
            oreg_reg_q    <= oreg_reg_d;
            oreg_addr_q   <= oreg_addr_d;
            oreg_wdata_q  <= oreg_wdata_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            tag_mem_q     <= tag_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_data_q    <= rsp_data_d;
            err_q         <= err_d;
        end
    end

    assign rf_req_vld         = oreg_vld_q;
    assign rf_req_wr          = oreg_wr_q;
    assign rf_req_reg         = oreg_reg_q;
    assign rf_req_addr        = oreg_addr_q;
    assign rf_req_wdata       = oreg_wdata_q;
    assign rsp_vld            = rsp_vld_q;
    assign rsp_data           = rsp_data_q;
    assign err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_vreg_port_arbiter.sv
// Randomized bench for vreg_port_arbiter against a queue-based reference model.
module tb_vreg_port_arbiter;

    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int RW   = 5;
    localparam int AW   = 4;
    localparam int MAXO = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           req_vld;
    logic [N-1:0]           req_wr;
    logic [N-1:0][RW-1:0]   req_reg;
    logic [N-1:0][AW-1:0]   req_addr;
    logic [N-1:0][DW-1:0]   req_wdata;
    logic [N-1:0]           req_grant;
    logic [N-1:0]           rsp_vld;
    logic [DW-1:0]          rsp_data;
    logic                   rf_req_vld;
    logic                   rf_req_wr;
    logic [RW-1:0]          rf_req_reg;
    logic [AW-1:0]          rf_req_addr;
    logic [DW-1:0]          rf_req_wdata;
    logic                   rf_busy;
    logic                   rf_rsp_vld;
    logic [DW-1:0]          rf_rsp_data;
    logic                   err_unexpected_rsp;

    always #5 clk = ~clk;

    vreg_port_arbiter #(
        .NUM_REQ          (N),
        .DATA_W           (DW),
        .REG_W            (RW),
        .ADDR_W           (AW),
        .MAX_OUTSTANDING  (MAXO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_vld            (req_vld),
        .req_wr             (req_wr),
        .req_reg            (req_reg),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_grant          (req_grant),
        .rsp_vld            (rsp_vld),
        .rsp_data           (rsp_data),
        .rf_req_vld         (rf_req_vld),
        .rf_req_wr          (rf_req_wr),
        .rf_req_reg         (rf_req_reg),
        .rf_req_addr        (rf_req_addr),
        .rf_req_wdata       (rf_req_wdata),
        .rf_busy            (rf_busy),
        .rf_rsp_vld         (rf_rsp_vld),
        .rf_rsp_data        (rf_rsp_data),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pending requests held by each requester until granted.
    bit            pend [N];
    bit            p_wr [N];
    logic [RW-1:0] p_reg [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_wdata [N];

    // Reference model state.
    int            m_rr;
    bit            m_ovld;
    bit            m_owr;
    logic [RW-1:0] m_oreg;
    logic [AW-1:0] m_oaddr;
    logic [DW-1:0] m_owdata;
    int            m_tags [$];   // requesters with reads in flight, oldest first
    logic [DW-1:0] m_rfq [$];    // read data the register file still owes
    logic [N-1:0]  m_rsp;
    logic [DW-1:0] m_rsp_data;
    bit            m_err;

    task automatic model_reset();
        m_rr = 0; m_ovld = 0; m_owr = 0; m_oreg = '0; m_oaddr = '0; m_owdata = '0;
        m_tags.delete(); m_rfq.delete();
        m_rsp = '0; m_rsp_data = '0; m_err = 0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) pend[i] = 0;
        req_vld = '0; req_wr = '0; req_reg = '0; req_addr = '0; req_wdata = '0;
        rf_busy = 0; rf_rsp_vld = 0; rf_rsp_data = '0;
    endtask

    // One clock cycle: drive stimulus, check DUT against model, advance model.
    task automatic run_cycle(input int gen_pct, input int wr_pct, input int busy_pct,
                             input int rsp_pct, input bit force_rsp);
        bit            rsp_in, pop, rd_ok;
        int            g;
        logic [N-1:0]  exp_g;
        logic [DW-1:0] rdata;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && int'($urandom_range(99)) < gen_pct) begin
                pend[i]    = 1;
                p_wr[i]    = int'($urandom_range(99)) < wr_pct;
                p_reg[i]   = RW'($urandom);
                p_addr[i]  = AW'($urandom);
                p_wdata[i] = {$urandom, $urandom};
            end
            req_vld[i]   = pend[i];
            req_wr[i]    = p_wr[i];
            req_reg[i]   = p_reg[i];
            req_addr[i]  = p_addr[i];
            req_wdata[i] = p_wdata[i];
        end
        rf_busy     = int'($urandom_range(99)) < busy_pct;
        rsp_in      = force_rsp || (m_rfq.size() > 0 && int'($urandom_range(99)) < rsp_pct);
        rdata       = (m_rfq.size() > 0) ? m_rfq[0] : {$urandom, $urandom};
        rf_rsp_vld  = rsp_in;
        rf_rsp_data = rdata;
        #3;
        pop   = rsp_in && m_tags.size() > 0;
        rd_ok = m_tags.size() < MAXO || pop;
        g     = -1;
        if (!m_ovld || !rf_busy) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_rr + k) % N;
                if (g < 0 && pend[idx] && (p_wr[idx] || rd_ok)) g = idx;
            end
        end
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        check_eq("req_grant", req_grant, exp_g);
        check_eq("rf_req_vld", rf_req_vld, m_ovld);
        check_eq("rf_req_wr", rf_req_wr, m_owr);
        check_eq("rf_req_reg", rf_req_reg, m_oreg);
        check_eq("rf_req_addr", rf_req_addr, m_oaddr);
        check_eq("rf_req_wdata", rf_req_wdata, m_owdata);
        check_eq("rsp_vld", rsp_vld, m_rsp);
        check_eq("rsp_data", rsp_data, m_rsp_data);
        check_eq("err_unexpected_rsp", err_unexpected_rsp, m_err);
        // Advance the model to the state after this clock edge.
        if (rsp_in && m_rfq.size() > 0) void'(m_rfq.pop_front());
        if (rsp_in && m_tags.size() == 0) m_err = 1;
        m_rsp = '0;
        if (pop) begin
            m_rsp[m_tags.pop_front()] = 1'b1;
            m_rsp_data = rdata;
        end
        if (m_ovld && !rf_busy && !m_owr) m_rfq.push_back({$urandom, $urandom});
        if (g >= 0) begin
            m_ovld   = 1;
            m_owr    = p_wr[g];
            m_oreg   = p_reg[g];
            m_oaddr  = p_addr[g];
            m_owdata = p_wdata[g];
            m_rr     = (g + 1) % N;
            if (!p_wr[g]) m_tags.push_back(g);
            pend[g] = 0;
        end else if (m_ovld && !rf_busy) begin
            m_ovld = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clear_reqs();
        model_reset();
        #12;
        check_eq("reset rf_req_vld", rf_req_vld, 1'b0);
        check_eq("reset rsp_vld", rsp_vld, '0);
        check_eq("reset err", err_unexpected_rsp, 1'b0);
        check_eq("reset rf_req_wdata", rf_req_wdata, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single read from requester 2: reg 5, addr 3.
        pend[2] = 1; p_wr[2] = 0; p_reg[2] = 5'd5; p_addr[2] = 4'd3; p_wdata[2] = '0;
        repeat (4) run_cycle(0, 0, 0, 0, 0);
        repeat (3) run_cycle(0, 0, 0, 100, 0);

        // All requesters writing continuously: rotating grants.
        repeat (16) run_cycle(100, 100, 0, 0, 0);
        // Reads only, no responses: outstanding limit, then release.
        repeat (10) run_cycle(100, 0, 0, 0, 0);
        repeat (10) run_cycle(100, 30, 0, 50, 0);
        // Heavy backpressure.
        repeat (30) run_cycle(80, 50, 75, 40, 0);
        // Mixed random traffic.
        repeat (400) run_cycle(50, 50, 30, 40, 0);
        // Drain.
        repeat (30) run_cycle(0, 0, 0, 100, 0);

        // Unexpected response with nothing outstanding: sticky error.
        clear_reqs();
        run_cycle(0, 0, 0, 0, 1);
        repeat (4) run_cycle(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a burst.
        repeat (20) run_cycle(90, 40, 20, 30, 0);
        reset = 1'b0;
        #1;
        check_eq("async rst rf_req_vld", rf_req_vld, 1'b0);
        check_eq("async rst rsp_vld", rsp_vld, '0);
        check_eq("async rst err", err_unexpected_rsp, 1'b0);
        check_eq("async rst req_grant", req_grant, '0);
        check_eq("async rst rsp_data", rsp_data, '0);
        check_eq("async rst rf_req_reg", rf_req_reg, '0);
        clear_reqs();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        // A response after reset has no tag left to match.
        run_cycle(0, 0, 0, 0, 1);
        repeat (3) run_cycle(0, 0, 0, 0, 0);
        repeat (60) run_cycle(50, 50, 30, 40, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
